seq_add_checker: RTL
====================

# seq_add_checker

Multi-cycle, parametrised successor to the combinational NOR-adder flag checker. It accepts one WIDTH-bit word, adds the constant KEY plus carry-in KEY_CIN over WIDTH/CHUNK cycles through a CHUNK-bit ripple slice with a registered carry, and XORs the sum against EXPECT. It reports the difference vector, the final carry and a match flag. It sits between a word source and the verdict logic, and trades latency for a CHUNK-bit adder instead of a full-width one.

## Interface
- WIDTH, 256: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 16: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- KEY, 0: WIDTH-bit addend constant.
- KEY_CIN, 0: 1-bit carry-in applied to slice 0.
- EXPECT, 0: WIDTH-bit expected sum.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  operand.
- res_valid  output  1  result is valid.
- res_ready  input  1  consumer accepts the result.
- res_diff  output  WIDTH  (in_data + KEY + KEY_CIN) mod 2^WIDTH, XOR EXPECT.
- res_carry  output  1  carry out of the MSB of the sum.
- res_match  output  1  1 when res_diff is all zero; res_carry is ignored.

## Operation
- N = WIDTH/CHUNK slices; a slice-index counter of width clog2(N), minimum 1.
- FSM states IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: in_ready=1. When in_valid & in_ready, capture in_data into the operand register, set carry=KEY_CIN, set idx=0, clear the diff register and the OR-accumulator, then go to RUN.
- RUN: in_ready=0. Each cycle computes {c,s} = op[idx*CHUNK +: CHUNK] + KEY[idx*CHUNK +: CHUNK] + carry.
  - Write s ^ EXPECT slice into diff[idx*CHUNK +: CHUNK].
  - OR the reduction of that slice into the accumulator.
  - Set carry=c and increment idx.
  - When idx==N-1, go to DONE.
- DONE: res_valid=1. Outputs hold stable until res_valid & res_ready, then go to IDLE. in_data is ignored outside IDLE.
- Adds are modulo 2^WIDTH, and carry propagates only through the registered carry. res_carry is the carry after slice N-1.
- res_match = ~accumulator.
- Reset values: in_ready=0 while rst_n is low and 1 after release; res_valid=0, res_diff=0, res_carry=0, res_match=0.
- Reset mid-RUN or mid-DONE aborts immediately; the pending result is discarded.

## Timing
- Latency: res_valid rises N cycles after the accepting edge.
- One word in flight at a time; no input skid. in_ready rises the cycle after the result handshake.
- Minimum issue interval is N+2 cycles when res_ready is held at 1.
- Outputs are registered; no combinational path from in_* to res_*.
- When N=1 (CHUNK=WIDTH), RUN lasts exactly one cycle.

## Configuration
- SEQ_ADD_CHECKER_DIFF_EN.
  - Defined: res_diff is the full registered difference vector as above.
  - Undefined: the diff register is not built and res_diff is tied to 0. res_match and res_carry behave identically, saving WIDTH flops.

## Test plan
- WIDTH=32, CHUNK=8, KEY=32'h000000FF, KEY_CIN=0, EXPECT=32'h00000100; in_data=1 -> after 4 cycles res_valid=1, res_diff=0, res_match=1, res_carry=0.
- Same parameters; in_data=32'hFFFFFF01 -> sum wraps to 0, res_carry=1, res_diff=32'h00000100, res_match=0. This checks carry ripple across all four slices.
- KEY_CIN=1, KEY=0, EXPECT=32'h00000000; in_data=32'hFFFFFFFF -> res_diff=0, res_match=1, res_carry=1.
- Hold res_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. Pulse res_ready -> in_ready=1 on the next cycle.
- Assert rst_n=0 during cycle 2 of RUN -> res_valid=0 and all res_* zero immediately. After release, a fresh word gives the correct result with full 4-cycle latency.
- WIDTH=256, CHUNK=16, KEY/KEY_CIN/EXPECT taken from the legacy checker constants; ASCII flag "ictf{" plus 26 zero bytes plus "}" -> res_diff equals the legacy combinational output bit-for-bit after 16 cycles.

Source files
------------

// File: rtl/seq_add_checker.sv
// seq_add_checker: adds KEY+KEY_CIN to a word CHUNK bits per cycle, compares to EXPECT.
// Define SEQ_ADD_CHECKER_DIFF_EN to build the registered res_diff vector.
module seq_add_checker #(
  parameter int               WIDTH   = 256,
  parameter int               CHUNK   = 16,
  parameter logic [WIDTH-1:0] KEY     = '0,
  parameter logic             KEY_CIN = 1'b0,
  parameter logic [WIDTH-1:0] EXPECT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_diff,
  output logic             res_carry,
  output logic             res_match
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_op;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_acc;

  logic [31:0]      w_sh;
  logic [CHUNK-1:0] w_key_s;
  logic [CHUNK-1:0] w_exp_s;
  logic [CHUNK-1:0] w_sum;
  logic [CHUNK-1:0] w_dslice;
  logic             w_c;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_op_nxt;

  assign w_sh    = 32'(r_idx) * 32'(CHUNK);
  assign w_key_s = CHUNK'(KEY >> w_sh);
  assign w_exp_s = CHUNK'(EXPECT >> w_sh);

  assign {w_c, w_sum} = {1'b0, r_op[CHUNK-1:0]}
                      + {1'b0, w_key_s}
                      + (CHUNK+1)'(r_carry);

  assign w_dslice = w_sum ^ w_exp_s;
  assign w_last   = (r_idx == IW'(N - 1));

  // Operand shifts down so the active slice is always at bit 0.
  if (N == 1) begin : g_op_one
    assign w_op_nxt = r_op;
  end else begin : g_op_many
    assign w_op_nxt = {{CHUNK{1'b0}}, r_op[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_acc   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= in_data;
            r_carry <= KEY_CIN;
            r_idx   <= '0;
            r_acc   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_op    <= w_op_nxt;
          r_carry <= w_c;
          r_acc   <= r_acc | (|w_dslice);
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_ADD_CHECKER_DIFF_EN
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_diff_nxt;

  // Slices enter at the top; after N shifts slice 0 sits at bit 0.
  if (N == 1) begin : g_diff_one
    assign w_diff_nxt = w_dslice;
  end else begin : g_diff_many
    assign w_diff_nxt = {w_dslice, r_diff[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_diff <= '0;
    end else if (r_state == S_RUN) begin
      r_diff <= w_diff_nxt;
    end
  end

  assign res_diff = r_diff;
`else
  assign res_diff = '0;
`endif

  assign w_done    = (r_state == S_DONE);
  assign in_ready  = (r_state == S_IDLE) & rst_n;
  assign res_valid = w_done;
  assign res_carry = w_done & r_carry;
  assign res_match = w_done & ~r_acc;

endmodule
